// File: rtl/pcpu_pkg.sv
// Shared definitions for the processor data-memory path: requester owner
// encodings, the default loader starvation bound and the response tag type.
package pcpu_pkg;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LDR = 1'b1;

   localparam int STARVE_MAX_DEFAULT = 4;

   // One entry of the read-response routing pipeline.
   typedef struct packed {
      logic valid;
      logic owner;
   } rsp_tag_t;

   localparam rsp_tag_t TAG_IDLE = '{valid: 1'b0, owner: 1'b0};

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Read-response pipeline: carries (valid, owner) of each granted read for two
// cycles so the memory's registered data returns to the port that asked.
module dmem_rsp_pipe
   import pcpu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_owner,
   input  logic [15:0] d_datain,
   output logic        c_rvalid,
   output logic [15:0] c_rdata,
   output logic        l_rvalid,
   output logic [15:0] l_rdata
);

   rsp_tag_t tag_a;   // read issued last cycle, memory data arriving now
   rsp_tag_t tag_b;   // read whose data is being presented this cycle

   // Stage A: remember the read issued in the grant cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_a <= TAG_IDLE;
      end else begin
         tag_a <= '{valid: issue_valid, owner: issue_owner};
      end
   end

   // Stage B: advance the tag alongside the captured read data.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_b <= TAG_IDLE;
      end else begin
         tag_b <= tag_a;
      end
   end

   // Capture memory data into the owning port; the other port keeps its value.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         c_rdata <= 16'h0000;
         l_rdata <= 16'h0000;
      end else if (tag_a.valid) begin
         if (tag_a.owner == OWN_LDR) begin
            l_rdata <= d_datain;
         end else begin
            c_rdata <= d_datain;
         end
      end else begin
         c_rdata <= c_rdata;
         l_rdata <= l_rdata;
      end
   end

   assign c_rvalid = tag_b.valid && (tag_b.owner == OWN_CPU);
   assign l_rvalid = tag_b.valid && (tag_b.owner == OWN_LDR);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and a debug/DMA loader.
// The CPU has priority, but the loader is guaranteed a slot once it has
// waited STARVE_MAX consecutive cycles behind the CPU.
module dmem_arbiter
   import pcpu_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
   parameter int ADDR_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [15:0]       c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [15:0]       c_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [15:0]       l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [15:0]       l_rdata,
   output logic [ADDR_W-1:0] d_addr,
   output logic [15:0]       d_dataout,
   output logic              d_we,
   input  logic [15:0]       d_datain
);

   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

   logic [CNT_W-1:0] starve_cnt;
   logic             issue_valid;
   logic             issue_owner;

   // Grant decision: CPU first unless the loader has hit its waiting limit.
   always_comb begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
      if (reset) begin
         c_gnt = 1'b0;
         l_gnt = 1'b0;
      end else if (c_req && l_req) begin
         if (starve_cnt == STARVE_LIM) begin
            l_gnt = 1'b1;
         end else begin
            c_gnt = 1'b1;
         end
      end else if (c_req) begin
         c_gnt = 1'b1;
      end else if (l_req) begin
         l_gnt = 1'b1;
      end else begin
         c_gnt = 1'b0;
         l_gnt = 1'b0;
      end
   end

   // Count consecutive cycles the loader has been held off by the CPU.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt <= CNT_ZERO;
      end else if (l_gnt || !l_req) begin
         starve_cnt <= CNT_ZERO;
      end else if (c_gnt && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + CNT_ONE;
      end else begin
         starve_cnt <= starve_cnt;
      end
   end

   // Steer the granted requester's fields onto the memory port.
   always_comb begin
      d_addr    = c_addr;
      d_dataout = c_wdata;
      d_we      = 1'b0;
      if (l_gnt) begin
         d_addr    = l_addr;
         d_dataout = l_wdata;
         d_we      = l_we;
      end else if (c_gnt) begin
         d_we      = c_we;
      end else begin
         d_we      = 1'b0;
      end
   end

   assign issue_valid = (c_gnt && !c_we) || (l_gnt && !l_we);
   assign issue_owner = l_gnt ? OWN_LDR : OWN_CPU;

   dmem_rsp_pipe u_rsp_pipe (
      .clock       (clock),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_owner (issue_owner),
      .d_datain    (d_datain),
      .c_rvalid    (c_rvalid),
      .c_rdata     (c_rdata),
      .l_rvalid    (l_rvalid),
      .l_rdata     (l_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model (loader waiting
// count, shadow memory, queue of responses due at a given cycle).
module tb_dmem_arbiter;

   localparam int SM = 4;
   localparam int AW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          c_req, c_we, l_req, l_we;
   logic [AW-1:0] c_addr, l_addr;
   logic [15:0]   c_wdata, l_wdata;
   logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
   logic [15:0]   c_rdata, l_rdata;
   logic [AW-1:0] d_addr;
   logic [15:0]   d_dataout, d_datain;
   logic          d_we;

   always #5 clock = ~clock;

   dmem_arbiter #(.STARVE_MAX(SM), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain)
   );

   // Synchronous memory attached to the arbiter's memory port.
   logic [15:0] mem [0:65535];
   always @(posedge clock) begin
      if (d_we) mem[d_addr] <= d_dataout;
      d_datain <= mem[d_addr];
   end

   // Reference model state.
   typedef struct {
      bit          owner;   // 1 = loader
      logic [15:0] data;
      int          due;
   } rsp_t;

   logic [15:0] shadow [0:65535];
   rsp_t        pend[$];
   int          wait_cnt;
   int          cyc;
   logic [15:0] exp_crd, exp_lrd;
   int          checks = 0;
   int          errors = 0;
   logic        obs_cgnt, obs_lgnt, obs_crv, obs_lrv;
   logic [15:0] obs_crd, obs_lrd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic idle();
      c_req = 1'b0; l_req = 1'b0; c_we = 1'b0; l_we = 1'b0;
   endtask

   // One clock cycle with the currently driven inputs; checks, then advances the model.
   task automatic step();
      bit eg_c, eg_l, ev_c, ev_l, we;
      logic [AW-1:0] addr;
      logic [15:0]   wd;
      eg_c = 1'b0; eg_l = 1'b0; ev_c = 1'b0; ev_l = 1'b0;
      if (c_req && l_req) begin
         if (wait_cnt == SM) eg_l = 1'b1; else eg_c = 1'b1;
      end else if (c_req) eg_c = 1'b1;
      else if (l_req) eg_l = 1'b1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         if (pend[0].owner) begin ev_l = 1'b1; exp_lrd = pend[0].data; end
         else begin ev_c = 1'b1; exp_crd = pend[0].data; end
         void'(pend.pop_front());
      end
      @(negedge clock);
      obs_cgnt = c_gnt; obs_lgnt = l_gnt; obs_crv = c_rvalid; obs_lrv = l_rvalid;
      obs_crd = c_rdata; obs_lrd = l_rdata;
      chk("c_gnt", 32'(c_gnt), 32'(eg_c));
      chk("l_gnt", 32'(l_gnt), 32'(eg_l));
      chk("d_we", 32'(d_we), 32'((eg_c && c_we) || (eg_l && l_we)));
      if (eg_c || eg_l) chk("d_addr", 32'(d_addr), 32'(eg_l ? l_addr : c_addr));
      if ((eg_c && c_we) || (eg_l && l_we))
         chk("d_dataout", 32'(d_dataout), 32'(eg_l ? l_wdata : c_wdata));
      chk("c_rvalid", 32'(c_rvalid), 32'(ev_c));
      chk("l_rvalid", 32'(l_rvalid), 32'(ev_l));
      chk("c_rdata", 32'(c_rdata), 32'(exp_crd));
      chk("l_rdata", 32'(l_rdata), 32'(exp_lrd));
      @(posedge clock);
      if (eg_c || eg_l) begin
         we   = eg_l ? l_we : c_we;
         addr = eg_l ? l_addr : c_addr;
         wd   = eg_l ? l_wdata : c_wdata;
         if (we) shadow[addr] = wd;
         else pend.push_back('{owner: eg_l, data: shadow[addr], due: cyc + 2});
      end
      if (eg_l || !l_req) wait_cnt = 0;
      else if (eg_c && wait_cnt < SM) wait_cnt++;
      cyc++;
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_c_gnt"}, 32'(c_gnt), 32'd0);
      chk({tag, "_l_gnt"}, 32'(l_gnt), 32'd0);
      chk({tag, "_d_we"}, 32'(d_we), 32'd0);
      chk({tag, "_c_rvalid"}, 32'(c_rvalid), 32'd0);
      chk({tag, "_l_rvalid"}, 32'(l_rvalid), 32'd0);
      chk({tag, "_c_rdata"}, 32'(c_rdata), 32'd0);
      chk({tag, "_l_rdata"}, 32'(l_rdata), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      c_addr = '0; l_addr = '0; c_wdata = 16'h0000; l_wdata = 16'h0000;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'h0000; shadow[i] = 16'h0000;
      end
      mem[16'h0010] = 16'hBEEF; shadow[16'h0010] = 16'hBEEF;
      mem[16'h0001] = 16'h1111; shadow[16'h0001] = 16'h1111;
      mem[16'h0002] = 16'h2222; shadow[16'h0002] = 16'h2222;
      mem[16'h0003] = 16'h3333; shadow[16'h0003] = 16'h3333;
      wait_cnt = 0; cyc = 0; exp_crd = 16'h0000; exp_lrd = 16'h0000;
      c_req = 1'b1; l_req = 1'b1;   // requests ignored while in reset
      repeat (2) @(posedge clock);
      #1;
      chk_reset_outputs("init");
      idle();
      reset = 1'b0;

      // CPU read of 0x0010 in the very first cycle out of reset.
      c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
      step();
      chk("rd_c_gnt0", 32'(obs_cgnt), 32'd1);
      idle();
      step();
      step();
      chk("rd_c_rvalid2", 32'(obs_crv), 32'd1);
      chk("rd_c_rdata2", 32'(obs_crd), 32'h0000BEEF);
      chk("rd_l_rvalid2", 32'(obs_lrv), 32'd0);
      step();

      // CPU write then loader read-back of the same address.
      c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0020; c_wdata = 16'h1234;
      step();
      idle();
      l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0020;
      step();
      chk("wr_l_gnt", 32'(obs_lgnt), 32'd1);
      idle();
      step();
      step();
      chk("wr_l_rvalid", 32'(obs_lrv), 32'd1);
      chk("wr_l_rdata", 32'(obs_lrd), 32'h00001234);

      // Alternating owners, back-to-back reads.
      c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0001;
      step();
      idle(); l_req = 1'b1; l_addr = 16'h0002;
      step();
      idle(); c_req = 1'b1; c_addr = 16'h0003;
      step();
      chk("alt_c_rv0", 32'(obs_crv), 32'd1);
      chk("alt_c_rd0", 32'(obs_crd), 32'h00001111);
      idle();
      step();
      chk("alt_l_rv1", 32'(obs_lrv), 32'd1);
      chk("alt_l_rd1", 32'(obs_lrd), 32'h00002222);
      step();
      chk("alt_c_rv2", 32'(obs_crv), 32'd1);
      chk("alt_c_rd2", 32'(obs_crd), 32'h00003333);
      step();

      // Both ports saturated: loader gets every (SM+1)th slot.
      c_req = 1'b1; l_req = 1'b1; c_we = 1'b1; l_we = 1'b1;
      c_addr = 16'h0040; l_addr = 16'h0041;
      for (int i = 0; i < 10; i++) begin
         c_wdata = 16'(i); l_wdata = 16'(16'h0100 + i);
         step();
         chk("starve_l_gnt", 32'(obs_lgnt), 32'((i == SM) || (i == 2 * SM + 1)));
      end
      idle();
      step();

      // Reset in the cycle after a CPU read grant drops the read.
      c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
      step();
      idle();
      c_req = 1'b1; l_req = 1'b1;
      reset = 1'b1;
      #1;
      chk_reset_outputs("rst");
      pend.delete(); wait_cnt = 0; exp_crd = 16'h0000; exp_lrd = 16'h0000;
      repeat (2) @(posedge clock);
      #1;
      chk_reset_outputs("rst_hold");
      idle();
      reset = 1'b0;
      repeat (4) begin
         step();
         chk("post_rst_c_rv", 32'(obs_crv), 32'd0);
      end

      // Random traffic over a small address window.
      for (int i = 0; i < 400; i++) begin
         c_req   = ($urandom_range(0, 3) != 0);
         l_req   = ($urandom_range(0, 2) != 0);
         c_we    = $urandom_range(0, 1) == 1;
         l_we    = $urandom_range(0, 1) == 1;
         c_addr  = 16'($urandom_range(0, 15));
         l_addr  = 16'($urandom_range(0, 15));
         c_wdata = 16'($urandom);
         l_wdata = 16'($urandom);
         step();
      end
      idle();
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive cycles the loader may wait while the CPU is granted.
REQ-002 Parameter ADDR_W, default 16: data memory address width.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 c_req  input  1  CPU MEM-stage access request.
REQ-006 c_we  input  1  CPU write (1) or read (0).
REQ-007 c_addr  input  ADDR_W  CPU address.
REQ-008 c_wdata  input  16  CPU write data.
REQ-009 c_gnt  output  1  CPU access issued this cycle; low while c_req is high means stall.
REQ-010 c_rvalid  output  1  CPU read data valid.
REQ-011 c_rdata  output  16  CPU read data.
REQ-012 l_req, l_we, l_addr, l_wdata  input  1/1/ADDR_W/16  loader (debug/DMA) request port, same meaning as the CPU port.
REQ-013 l_gnt, l_rvalid, l_rdata  output  1/1/16  loader grant and response, same meaning as the CPU port.
REQ-014 d_addr  output  ADDR_W  data memory address.
REQ-015 d_dataout  output  16  data memory write data.
REQ-016 d_we  output  1  data memory write enable.
REQ-017 d_datain  input  16  synchronous memory read data, valid one cycle after the address is issued.

Function
REQ-018 Grant is combinational from the current requests and the registered starvation counter; at most one of c_gnt and l_gnt is high in any cycle.
REQ-019 Only c_req high: c_gnt=1. Only l_req high: l_gnt=1. Neither high: both grants 0, d_we=0.
REQ-020 Both high: the CPU wins unless starve_cnt equals STARVE_MAX, in which case the loader wins.
REQ-021 starve_cnt increments when l_req=1 and c_gnt=1, clears when l_gnt=1 or l_req=0, and saturates at STARVE_MAX.
REQ-022 d_addr, d_dataout and d_we mux the granted requester's fields in the grant cycle; d_we=0 when there is no grant.
REQ-023 A granted read in cycle N: d_datain is registered at the end of cycle N+1; x_rvalid=1 with x_rdata valid in cycle N+2 for exactly one cycle.
REQ-024 Response routing uses a two-stage tag pipeline (valid, owner), so back-to-back reads from alternating owners each return to the correct port in order.
REQ-025 Granted writes produce no rvalid.
REQ-026 x_rdata holds its last value when x_rvalid=0.
REQ-027 A request dropped before its grant is discarded with no side effect.
REQ-028 Sustained traffic from both ports: the loader receives exactly one grant in every STARVE_MAX+1 cycles.

Reset
REQ-029 On reset assertion, starve_cnt, the tag pipeline, c_rvalid, l_rvalid, c_rdata and l_rdata clear to 0 immediately, without waiting for a clock edge.
REQ-030 While reset is high, c_gnt, l_gnt and d_we are forced to 0.
REQ-031 A read in flight when reset asserts is dropped; no rvalid follows after reset deasserts.
REQ-032 The first cycle after reset deasserts arbitrates normally.

Structure
REQ-033 Owner encodings (OWN_CPU=0, OWN_LDR=1) and the default STARVE_MAX belong in the shared package pcpu_pkg.
REQ-034 The response tag and data pipeline is one sub-module, dmem_rsp_pipe.
REQ-035 The arbitration logic and the starvation counter stay in the top module.

Verification
REQ-036 CPU read only, c_addr=0x0010, memory[0x0010]=0xBEEF -> c_gnt in cycle 0; c_rvalid=1 with c_rdata=0xBEEF in cycle 2; l_rvalid stays 0.
REQ-037 CPU write 0x1234 to 0x0020, then loader read of 0x0020 -> d_we=1 for one cycle; l_rdata=0x1234 two cycles after l_gnt.
REQ-038 c_req and l_req both held high for 10 cycles with STARVE_MAX=4 -> l_gnt in cycles 4 and 9 only; c_gnt in all other cycles.
REQ-039 Alternating reads CPU 0x0001 / loader 0x0002 / CPU 0x0003, each granted on a successive cycle -> rvalid pulses on the CPU, loader, CPU ports in that order, carrying the matching data.
REQ-040 Reset asserted in the cycle after a CPU read grant -> no c_rvalid afterwards; all outputs read 0 during reset.
